// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM states, opcodes, bubble word,
// byte-enable patterns and opcode decode helpers.
package mem_stage_pkg;

  typedef enum logic {
    MS_IDLE,
    MS_BUSY
  } msState_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } accSize_e;

  localparam logic [5:0] OP_LD = 6'h20;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SD = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  // Bubble instruction; its opcode decodes as a non-memory op.
  localparam logic [31:0] NOP = 32'hFC00_0000;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int CNT_W = 8;

  function automatic accSize_e accSize(input logic [5:0] op);
    accSize = SZ_NONE;
    case (op)
      OP_LW, OP_SW: accSize = SZ_WORD;
      OP_LH, OP_SH: accSize = SZ_HALF;
      OP_LD, OP_SD: accSize = SZ_BYTE;
      default:      accSize = SZ_NONE;
    endcase
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    isStore = (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align_unit: combinational byte-lane steering for stores and lane extract/sign-extend for loads.
// Misaligned detection is active only when MEM_ALIGN_CHECK_EN is defined.
module mem_align_unit
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       i_stOp,
  input  logic [1:0]       i_stAddrLo,
  input  logic [WIDTH-1:0] i_storeData,
  input  logic [5:0]       i_ldOp,
  input  logic [1:0]       i_ldAddrLo,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [3:0]       o_be,
  output logic [WIDTH-1:0] o_wdata,
  output logic [WIDTH-1:0] o_loadData,
  output logic             o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Narrow stores replicate the datum across every lane; be selects the lanes that land.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_storeData;
    case (accSize(i_stOp))
      SZ_WORD: begin
        o_be    = BE_WORD;
        o_wdata = i_storeData;
      end
      SZ_HALF: begin
        o_be    = i_stAddrLo[1] ? (BE_HALF << 2) : BE_HALF;
        o_wdata = {(WIDTH/16){i_storeData[15:0]}};
      end
      SZ_BYTE: begin
        o_be    = BE_BYTE << i_stAddrLo;
        o_wdata = {(WIDTH/8){i_storeData[7:0]}};
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = i_storeData;
      end
    endcase
  end

  always_comb begin
    w_byte     = i_rdata[{i_ldAddrLo, 3'b000} +: 8];
    w_half     = i_rdata[{i_ldAddrLo[1], 4'b0000} +: 16];
    o_loadData = i_rdata;
    case (accSize(i_ldOp))
      SZ_HALF: o_loadData = {{(WIDTH-16){w_half[15]}}, w_half};
      SZ_BYTE: o_loadData = {{(WIDTH-8){w_byte[7]}}, w_byte};
      default: o_loadData = i_rdata;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    case (accSize(i_stOp))
      SZ_WORD: o_misaligned = (i_stAddrLo != 2'b00);
      SZ_HALF: o_misaligned = i_stAddrLo[0];
      default: o_misaligned = 1'b0;
    endcase
  end
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage driving a req/ack data bus, stalling upstream while busy.
// Define MEM_ALIGN_CHECK_EN to trap misaligned LW/SW/LH/SH instead of silently aligning them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z,
  input  logic [WIDTH-1:0] Addr,
  output logic             IsStall,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] LMD,
  output logic             BusErr,
  output logic             Misaligned,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  msState_e         r_state;
  logic [CNT_W-1:0] r_count;
  logic [5:0]       r_op;
  logic [1:0]       r_addrLo;
  logic [WIDTH-1:0] r_irOut;
  logic [WIDTH-3:0] r_pcOut;
  logic [WIDTH-1:0] r_aluOut;
  logic [WIDTH-1:0] r_lmd;
  logic             r_busErr;
  logic             r_misaligned;
  logic             r_req;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_wdata;

  logic [5:0]       w_op;
  logic             w_isMem;
  logic             w_misaligned;
  logic             w_start;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_loadData;

  assign w_op    = IR_in[31:26];
  assign w_isMem = (accSize(w_op) != SZ_NONE);
  assign w_start = (r_state == MS_IDLE) && w_isMem && !w_misaligned;

  // Load extraction uses the op/offset latched at issue so the bus word is decoded consistently.
  mem_align_unit #(.WIDTH(WIDTH)) u_align (
    .i_stOp       (w_op),
    .i_stAddrLo   (Addr[1:0]),
    .i_storeData  (Z),
    .i_ldOp       (r_op),
    .i_ldAddrLo   (r_addrLo),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_loadData   (w_loadData),
    .o_misaligned (w_misaligned)
  );

  assign IsStall = (r_state == MS_IDLE) ? w_start : ~dmem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= MS_IDLE;
      r_count      <= '0;
      r_op         <= '0;
      r_addrLo     <= '0;
      r_irOut      <= NOP;
      r_pcOut      <= '0;
      r_aluOut     <= '0;
      r_lmd        <= '0;
      r_busErr     <= 1'b0;
      r_misaligned <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
    end else begin
      r_busErr     <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        MS_IDLE: begin
          if (w_start) begin
            r_state  <= MS_BUSY;
            r_count  <= '0;
            r_op     <= w_op;
            r_addrLo <= Addr[1:0];
            r_req    <= 1'b1;
            r_we     <= isStore(w_op);
            r_addr   <= {Addr[WIDTH-1:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_irOut  <= NOP;
          end else begin
            r_irOut  <= IR_in;
            r_pcOut  <= PC_in;
            r_aluOut <= Z;
            if (w_misaligned) begin
              r_lmd        <= '0;
              r_misaligned <= 1'b1;
            end
          end
        end
        MS_BUSY: begin
          // An ack in the final allowed cycle completes normally rather than aborting.
          if (dmem_ack) begin
            if (!isStore(r_op)) begin
              r_lmd <= w_loadData;
            end
            r_irOut  <= IR_in;
            r_pcOut  <= PC_in;
            r_aluOut <= Z;
            r_req    <= 1'b0;
            r_count  <= '0;
            r_state  <= MS_IDLE;
          end else if (r_count == LAST_CNT) begin
            r_lmd    <= '0;
            r_busErr <= 1'b1;
            r_irOut  <= IR_in;
            r_pcOut  <= PC_in;
            r_aluOut <= Z;
            r_req    <= 1'b0;
            r_count  <= '0;
            r_state  <= MS_IDLE;
          end else begin
            r_count <= r_count + 1'b1;
            r_irOut <= NOP;
          end
        end
        default: r_state <= MS_IDLE;
      endcase
    end
  end

  assign IR_out     = r_irOut;
  assign PC_out     = r_pcOut;
  assign ALUOut     = r_aluOut;
  assign LMD        = r_lmd;
  assign BusErr     = r_busErr;
  assign Misaligned = r_misaligned;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: spec-example vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int W  = 32;
  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] IR_in, Z, Addr, dmem_rdata;
  logic [W-3:0] PC_in;
  logic         dmem_ack;
  logic         IsStall, BusErr, Misaligned, dmem_req, dmem_we;
  logic [W-1:0] IR_out, ALUOut, LMD, dmem_addr, dmem_wdata;
  logic [W-3:0] PC_out;
  logic [3:0]   dmem_be;

  int checks     = 0;
  int failures   = 0;
  int stallCount = 0;

  bit           mBusy   = 1'b0;
  int           mWaited = 0;
  logic [5:0]   mOp;
  logic [W-1:0] mAddr;
  logic [W-1:0] eIr, eAlu, eLmd, eBusAddr, eWdata;
  logic [W-3:0] ePc;
  logic         eReq, eWe, eBusErr, eMis;
  logic [3:0]   eBe;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [31:0] z;
    logic [31:0] addr;
    logic [31:0] rdata;
    int         ackDelay;
    logic [31:0] expLmd;
    logic [3:0] expBe;
    logic [31:0] expWdata;
    logic [31:0] expBusAddr;
  } vec_t;

  vec_t vecs[8];
  logic [5:0] memOps[6];

  mem_stage #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .IR_in      (IR_in),
    .PC_in      (PC_in),
    .Z          (Z),
    .Addr       (Addr),
    .IsStall    (IsStall),
    .IR_out     (IR_out),
    .PC_out     (PC_out),
    .ALUOut     (ALUOut),
    .LMD        (LMD),
    .BusErr     (BusErr),
    .Misaligned (Misaligned),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  always #5 clk = ~clk;

  function automatic int sizeOf(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return 4;
      OP_LH, OP_SH: return 2;
      OP_LD, OP_SD: return 1;
      default:      return 0;
    endcase
  endfunction

  function automatic bit isStoreOp(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  function automatic bit refMisaligned(input logic [5:0] op, input logic [W-1:0] addr);
    int n = sizeOf(op);
    return ALIGN_CHECK && (n > 1) && ((addr % n) != 0);
  endfunction

  // Byte offset of the accessed datum inside the bus word; unaligned words are forced to lane 0.
  function automatic int refOffset(input logic [5:0] op, input logic [W-1:0] addr);
    int n = sizeOf(op);
    if (n == 1) return int'(addr % 4);
    if (n == 2) return int'((addr % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] refBe(input logic [5:0] op, input logic [W-1:0] addr);
    int n = sizeOf(op);
    return 4'(((1 << n) - 1) << refOffset(op, addr));
  endfunction

  function automatic logic [W-1:0] refWdata(input logic [5:0] op, input logic [W-1:0] z);
    int n = sizeOf(op);
    if (n == 2) return (z & 32'hFFFF) * 32'h0001_0001;
    if (n == 1) return (z & 32'hFF) * 32'h0101_0101;
    return z;
  endfunction

  function automatic logic [W-1:0] refLoad(input logic [5:0] op, input logic [W-1:0] addr,
                                           input logic [W-1:0] rd);
    int     n = sizeOf(op);
    longint v;
    longint half;
    if (n == 4) return rd;
    v    = longint'(rd >> (8 * refOffset(op, addr)));
    v    = v % (longint'(1) << (8 * n));
    half = longint'(1) << (8 * n - 1);
    if (v >= half) v = v - 2 * half;
    return 32'(v);
  endfunction

  task automatic modelReset();
    mBusy    = 1'b0;
    mWaited  = 0;
    eIr      = NOP;
    ePc      = '0;
    eAlu     = '0;
    eLmd     = '0;
    eBusAddr = '0;
    eWdata   = '0;
    eReq     = 1'b0;
    eWe      = 1'b0;
    eBe      = '0;
    eBusErr  = 1'b0;
    eMis     = 1'b0;
  endtask

  // One clock of the reference: predicts IsStall now and the outputs after the coming edge.
  task automatic modelStep(output logic expStall);
    logic [5:0] op;
    int         n;
    bit         mis;
    op  = IR_in[31:26];
    n   = sizeOf(op);
    mis = refMisaligned(op, Addr);
    expStall = mBusy ? !dmem_ack : ((n != 0) && !mis);
    eBusErr  = 1'b0;
    eMis     = 1'b0;
    if (rst) begin
      modelReset();
    end else if (!mBusy) begin
      if (n != 0 && !mis) begin
        mBusy    = 1'b1;
        mWaited  = 0;
        mOp      = op;
        mAddr    = Addr;
        eReq     = 1'b1;
        eWe      = isStoreOp(op);
        eBusAddr = Addr & ~32'h3;
        eBe      = refBe(op, Addr);
        eWdata   = refWdata(op, Z);
        eIr      = NOP;
      end else begin
        eIr  = IR_in;
        ePc  = PC_in;
        eAlu = Z;
        if (mis) begin
          eLmd = '0;
          eMis = 1'b1;
        end
      end
    end else if (dmem_ack) begin
      if (!isStoreOp(mOp)) eLmd = refLoad(mOp, mAddr, dmem_rdata);
      eIr   = IR_in;
      ePc   = PC_in;
      eAlu  = Z;
      eReq  = 1'b0;
      mBusy = 1'b0;
    end else if (mWaited == TO - 1) begin
      eLmd    = '0;
      eBusErr = 1'b1;
      eIr     = IR_in;
      ePc     = PC_in;
      eAlu    = Z;
      eReq    = 1'b0;
      mBusy   = 1'b0;
    end else begin
      mWaited++;
      eIr = NOP;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("IR_out",     64'(IR_out),     64'(eIr));
    checkOutput("PC_out",     64'(PC_out),     64'(ePc));
    checkOutput("ALUOut",     64'(ALUOut),     64'(eAlu));
    checkOutput("LMD",        64'(LMD),        64'(eLmd));
    checkOutput("BusErr",     64'(BusErr),     64'(eBusErr));
    checkOutput("Misaligned", 64'(Misaligned), 64'(eMis));
    checkOutput("dmem_req",   64'(dmem_req),   64'(eReq));
    checkOutput("dmem_we",    64'(dmem_we),    64'(eWe));
    checkOutput("dmem_addr",  64'(dmem_addr),  64'(eBusAddr));
    checkOutput("dmem_be",    64'(dmem_be),    64'(eBe));
    checkOutput("dmem_wdata", 64'(dmem_wdata), 64'(eWdata));
  endtask

  // Entered 1 time unit after a rising edge; checks IsStall mid-cycle and outputs after the edge.
  task automatic applyStimulus(input logic aRst, input logic aAck);
    logic expStall;
    rst      = aRst;
    dmem_ack = aAck;
    #3;
    modelStep(expStall);
    checkOutput("IsStall", 64'(IsStall), 64'(expStall));
    if (IsStall === 1'b1) stallCount++;
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic finishMemOp(input int ackDelay);
    int guard = 0;
    while (mBusy && guard < 16) begin
      applyStimulus(1'b0, (mWaited == ackDelay) ? 1'b1 : 1'b0);
      guard++;
    end
  endtask

  task automatic runInstr(input logic [W-1:0] ir, input logic [W-3:0] pc, input logic [W-1:0] z,
                          input logic [W-1:0] addr, input logic [W-1:0] rdata,
                          input int ackDelay, input logic idleAck);
    IR_in      = ir;
    PC_in      = pc;
    Z          = z;
    Addr       = addr;
    dmem_rdata = rdata;
    stallCount = 0;
    applyStimulus(1'b0, idleAck);
    finishMemOp(ackDelay);
  endtask

  initial begin
    vecs[0] = '{"LW_100", OP_LW, 32'h0,        32'h100, 32'hCAFE_BABE, 3, 32'hCAFE_BABE, 4'b1111, 32'h0,         32'h100};
    vecs[1] = '{"LH_102", OP_LH, 32'h0,        32'h102, 32'h8001_1234, 0, 32'hFFFF_8001, 4'b1100, 32'h0,         32'h100};
    vecs[2] = '{"LD_103", OP_LD, 32'h0,        32'h103, 32'h7F00_0000, 1, 32'h0000_007F, 4'b1000, 32'h0,         32'h100};
    vecs[3] = '{"LD_101", OP_LD, 32'h0,        32'h101, 32'h0000_8000, 2, 32'hFFFF_FF80, 4'b0010, 32'h0,         32'h100};
    vecs[4] = '{"LH_100", OP_LH, 32'h0,        32'h100, 32'h0000_7FFF, 0, 32'h0000_7FFF, 4'b0011, 32'h0,         32'h100};
    vecs[5] = '{"SH_0A2", OP_SH, 32'h1234,     32'h0A2, 32'h0,         0, 32'h0,         4'b1100, 32'h1234_1234, 32'h0A0};
    vecs[6] = '{"SW_104", OP_SW, 32'hDEAD_BEEF, 32'h104, 32'h0,        1, 32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h104};
    vecs[7] = '{"SD_0A3", OP_SD, 32'h55,       32'h0A3, 32'h0,         2, 32'h0,         4'b1000, 32'h5555_5555, 32'h0A0};
    memOps = '{OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};

    rst        = 1'b1;
    dmem_ack   = 1'b0;
    IR_in      = NOP;
    PC_in      = '0;
    Z          = '0;
    Addr       = '0;
    dmem_rdata = '0;
    @(posedge clk);
    #1;
    modelReset();
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_IR_out", 64'(IR_out),   64'(NOP));
    checkOutput("reset_req",    64'(dmem_req), 64'(0));

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      IR_in      = {vecs[i].op, 26'(i * 3 + 1)};
      PC_in      = 30'(32'h40 + i);
      Z          = vecs[i].z;
      Addr       = vecs[i].addr;
      dmem_rdata = vecs[i].rdata;
      stallCount = 0;
      applyStimulus(1'b0, 1'b0);
      checkOutput({vecs[i].name, "_req"},  64'(dmem_req),  64'(1));
      checkOutput({vecs[i].name, "_we"},   64'(dmem_we),   64'(isStoreOp(vecs[i].op)));
      checkOutput({vecs[i].name, "_be"},   64'(dmem_be),   64'(vecs[i].expBe));
      checkOutput({vecs[i].name, "_addr"}, 64'(dmem_addr), 64'(vecs[i].expBusAddr));
      if (isStoreOp(vecs[i].op))
        checkOutput({vecs[i].name, "_wdata"}, 64'(dmem_wdata), 64'(vecs[i].expWdata));
      finishMemOp(vecs[i].ackDelay);
      checkOutput({vecs[i].name, "_stalls"}, 64'(stallCount), 64'(vecs[i].ackDelay + 1));
      checkOutput({vecs[i].name, "_ir"},     64'(IR_out),     64'(IR_in));
      checkOutput({vecs[i].name, "_busErr"}, 64'(BusErr),     64'(0));
      if (!isStoreOp(vecs[i].op))
        checkOutput({vecs[i].name, "_lmd"}, 64'(LMD), 64'(vecs[i].expLmd));
    end

    $display("[TB] ADD then LW back to back");
    runInstr({6'h00, 26'h0ADD}, 30'h80, 32'h1111, 32'h0, 32'h0, 0, 1'b1);
    checkOutput("add_stalls", 64'(stallCount), 64'(0));
    checkOutput("add_aluout", 64'(ALUOut),     64'(32'h1111));
    checkOutput("add_ir",     64'(IR_out),     64'({6'h00, 26'h0ADD}));
    runInstr({OP_LW, 26'h1}, 30'h81, 32'h2222, 32'h100, 32'h0BAD_F00D, 0, 1'b0);
    checkOutput("lw_min_stalls", 64'(stallCount), 64'(1));
    checkOutput("lw_min_lmd",    64'(LMD),        64'(32'h0BAD_F00D));
    checkOutput("lw_min_alu",    64'(ALUOut),     64'(32'h2222));

    $display("[TB] timeout abort");
    runInstr({OP_LW, 26'h5}, 30'h90, 32'h0, 32'h300, 32'h1234_5678, 10, 1'b0);
    checkOutput("to_stalls", 64'(stallCount), 64'(TO + 1));
    checkOutput("to_busErr", 64'(BusErr),     64'(1));
    checkOutput("to_lmd",    64'(LMD),        64'(0));
    checkOutput("to_req",    64'(dmem_req),   64'(0));
    runInstr({6'h01, 26'h7}, 30'h91, 32'h3333, 32'h0, 32'h0, 0, 1'b1);
    checkOutput("to_busErr_pulse", 64'(BusErr), 64'(0));
    checkOutput("idle_ack_ir",     64'(IR_out), 64'({6'h01, 26'h7}));

    $display("[TB] reset while busy");
    IR_in = {OP_LW, 26'h9};
    PC_in = 30'hA0;
    Addr  = 32'h200;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rstbusy_req_before", 64'(dmem_req), 64'(1));
    applyStimulus(1'b1, 1'b1);
    checkOutput("rstbusy_req_after", 64'(dmem_req), 64'(0));
    checkOutput("rstbusy_ir",        64'(IR_out),   64'(NOP));
    IR_in = {6'h02, 26'h3};
    applyStimulus(1'b0, 1'b1);
    checkOutput("late_ack_req", 64'(dmem_req), 64'(0));
    checkOutput("late_ack_ir",  64'(IR_out),   64'({6'h02, 26'h3}));

    $display("[TB] misaligned word load");
    runInstr({OP_LW, 26'hB}, 30'hB0, 32'h0, 32'h101, 32'h1122_3344, 0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("mis_flag",   64'(Misaligned), 64'(1));
    checkOutput("mis_req",    64'(dmem_req),   64'(0));
    checkOutput("mis_lmd",    64'(LMD),        64'(0));
    checkOutput("mis_stalls", 64'(stallCount), 64'(0));
`else
    checkOutput("mis_flag", 64'(Misaligned), 64'(0));
    checkOutput("mis_lmd",  64'(LMD),        64'(32'h1122_3344));
    checkOutput("mis_addr", 64'(dmem_addr),  64'(32'h100));
`endif
    checkOutput("mis_ir", 64'(IR_out), 64'({OP_LW, 26'hB}));

    $display("[TB] random traffic");
    for (int i = 0; i < 250; i++) begin
      logic [5:0] op;
      int         pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 6) op = memOps[pick];
      else          op = 6'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      runInstr({op, 26'($urandom)}, 30'($urandom), $urandom, 32'($urandom_range(0, 4095)),
               $urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
